// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-register control encoding, and the pipeline/hazard-controller signal bundle.
// master = pipeline side (drives status), slave = controller side (drives stage control).
package pipe_pkg;
    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;
endpackage

interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
    import pipe_pkg::*;

    logic              ihit;
    logic              dhit;
    logic              dmem_req_mem;
    logic              halt_mem;
    logic              branch_taken_ex;
    logic              load_ex;
    logic [4:0]        rt_ex;
    logic [4:0]        rs_dec;
    logic [4:0]        rt_dec;
    logic              uses_rt_dec;
    logic              pc_en;
    pipe_state_t       fd_state;
    pipe_state_t       de_state;
    pipe_state_t       em_state;
    pipe_state_t       mw_state;
    logic              halted;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output ihit, dhit, dmem_req_mem, halt_mem, branch_taken_ex,
               load_ex, rt_ex, rs_dec, rt_dec, uses_rt_dec,
        input  pc_en, fd_state, de_state, em_state, mw_state, halted, stall_count
    );

    modport slave (
        input  ihit, dhit, dmem_req_mem, halt_mem, branch_taken_ex,
               load_ex, rt_ex, rs_dec, rt_dec, uses_rt_dec,
        output pc_en, fd_state, de_state, em_state, mw_state, halted, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard/sequencing controller with saturating stall counter.
// Latency: stage controls and pc_en are combinational (0 cycles); state, halted, stall_count registered. No backpressure beyond the stalls it issues.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    pipeline_hazard_ctrl_if.slave  hz
);
    import pipe_pkg::*;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } fsm_t;

    fsm_t              state;
    fsm_t              state_nxt;
    logic              halted_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              dstall;
    logic              load_use;
    logic              pc_en_c;
    pipe_state_t       fd_c;
    pipe_state_t       de_c;
    pipe_state_t       em_c;
    pipe_state_t       mw_c;

    assign dstall   = hz.dmem_req_mem && !hz.dhit;
    // A load into $0 never produces a real dependency.
    assign load_use = hz.load_ex && (hz.rt_ex != 5'd0) &&
                      ((hz.rt_ex == hz.rs_dec) ||
                       (hz.uses_rt_dec && (hz.rt_ex == hz.rt_dec)));

    always_comb begin
        state_nxt = state;
        pc_en_c   = 1'b1;
        fd_c      = PIPE_ENABLE;
        de_c      = PIPE_ENABLE;
        em_c      = PIPE_ENABLE;
        mw_c      = PIPE_ENABLE;
        if (state == HALT) begin
            pc_en_c = 1'b0;
            fd_c    = PIPE_STALL;
            de_c    = PIPE_STALL;
            em_c    = PIPE_STALL;
            mw_c    = PIPE_STALL;
        end else if (dstall) begin
            state_nxt = DWAIT;
            pc_en_c   = 1'b0;
            fd_c      = PIPE_STALL;
            de_c      = PIPE_STALL;
            em_c      = PIPE_STALL;
            mw_c      = PIPE_NOP;
        end else begin
            // DWAIT releases on the hit cycle, which is then resolved like RUN.
            state_nxt = RUN;
            if (hz.halt_mem) begin
                state_nxt = HALT;
                pc_en_c   = 1'b0;
                fd_c      = PIPE_STALL;
                de_c      = PIPE_STALL;
                em_c      = PIPE_NOP;
            end else if (hz.branch_taken_ex) begin
                fd_c = PIPE_NOP;
                de_c = PIPE_NOP;
            end else if (load_use) begin
                pc_en_c = 1'b0;
                fd_c    = PIPE_STALL;
                de_c    = PIPE_NOP;
            end else if (!hz.ihit) begin
                pc_en_c = 1'b0;
                fd_c    = PIPE_NOP;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            halted_q <= (state_nxt == HALT);
            if (!pc_en_c && (state != HALT) && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hz.pc_en       = pc_en_c;
    assign hz.fd_state    = fd_c;
    assign hz.de_state    = de_c;
    assign hz.em_state    = em_c;
    assign hz.mw_state    = mw_c;
    assign hz.halted      = halted_q;
    assign hz.stall_count = cnt_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage pipeline. Every cycle it drives the state of each inter-stage register (fetch/decode, decode/execute, execute/memory, memory/writeback) and the PC write enable. It resolves data-memory wait, taken branches and jumps, load-use hazards, instruction-fetch misses and halt. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- CNT_W, 32, width of stall_count

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous, active-low reset
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmem_req_mem  in  1  instruction in MEM issues dREN or dWEN
- halt_mem  in  1  instruction in MEM is halt
- branch_taken_ex  in  1  EX resolved a taken branch or jump, so PC redirects
- load_ex  in  1  instruction in EX is a load (dREN_ex)
- rt_ex  in  5  destination register of the load in EX
- rs_dec  in  5  rs field of the instruction in decode
- rt_dec  in  5  rt field of the instruction in decode
- uses_rt_dec  in  1  decode instruction reads rt as a source
- pc_en  out  1  PC register loads next PC
- fd_state, de_state, em_state, mw_state  out  pipe_state_t  each is PIPE_ENABLE, PIPE_STALL (hold) or PIPE_NOP (load bubble)
- halted  out  1  pipeline frozen after halt
- stall_count  out  CNT_W  cycles with pc_en=0 while not halted

## Operation
- FSM states are RUN, DWAIT and HALT. The reset state is RUN.
- Outputs are evaluated by priority, first match wins.
  1. **HALT state:** all four stages STALL, pc_en=0, halted=1. HALT is terminal; only reset leaves it.
  2. **Data stall** (RUN or DWAIT, dmem_req_mem=1, dhit=0): fd/de/em STALL, mw NOP, pc_en=0. Next state is DWAIT.
  3. **halt_mem=1:** mw ENABLE so the halt reaches WB. em NOP. fd/de STALL. pc_en=0. Next state is HALT.
  4. **branch_taken_ex=1:** fd NOP, de NOP, em ENABLE, mw ENABLE, pc_en=1.
  5. **Load-use hazard:** load_ex=1 and rt_ex≠0 and either rt_ex==rs_dec, or uses_rt_dec=1 and rt_ex==rt_dec. Then fd STALL, de NOP, em/mw ENABLE, pc_en=0.
  6. **Instruction miss** (ihit=0): fd NOP, de/em/mw ENABLE, pc_en=0.
  7. **Otherwise:** all four stages ENABLE, pc_en=1.
- **DWAIT state:** rule 2 applies while dhit=0. On the dhit=1 cycle the state returns to RUN, and rules 3–7 are evaluated in that same cycle with the current inputs.
- **halted output:** halted=1 only in the HALT state.
- **stall_count:**
  - Increments by 1 on every rising edge where pc_en=0 and the state is not HALT.
  - Saturates at all-ones.
  - Never wraps.

## Timing
- pc_en and the four stage-state outputs are combinational from the FSM state and the current inputs, with zero-cycle latency. The state, halted and stall_count are registered.
- **Reset:** asynchronous.
  - State goes to RUN, halted=0, stall_count=0.
  - While nRST=0, the stage-state outputs follow the RUN-state priority on the current inputs.
  - Reset asserted mid-DWAIT or in HALT returns the FSM to RUN immediately.
- **Data-miss penalty:** a miss lasting N cycles freezes fd/de/em and PC for exactly N cycles, with N bubbles entering WB. The dhit cycle advances normally.
- **Branch penalty:** exactly 2 bubbles, at decode/execute and fetch/decode, in the cycle the branch is in EX.
- **Load-use penalty:** exactly 1 bubble into EX. The second cycle then sees load_ex=0 and proceeds.
- **Simultaneous events:**
  - Branch plus load-use: the branch wins, because decode is flushed anyway.
  - Load-use plus ihit=0: fd holds, it is not NOP'd.
  - Branch plus ihit=0: PC is redirected anyway.
  - halt_mem plus branch_taken_ex: the halt wins and the branch is squashed (em NOP).
- A load into register $0 never stalls.

## Test plan
- **Reset, then idle:** nRST pulse, ihit=1, all other inputs 0 → all stages ENABLE, pc_en=1, halted=0, stall_count=0.
- **Data miss:** dmem_req_mem=1, dhit=0 for 3 cycles, then dhit=1.
  - For 3 cycles: fd/de/em STALL, mw NOP, pc_en=0.
  - 4th cycle: all ENABLE.
  - stall_count reads 3.
- **Load-use:** load_ex=1, rt_ex=5, rs_dec=5 for 1 cycle → de NOP, fd STALL, pc_en=0. The same stimulus with rt_ex=0 → all ENABLE. rt_dec=5 with uses_rt_dec=0 → no stall.
- **Branch collision:** branch_taken_ex=1 together with a load-use match and ihit=0 → fd NOP, de NOP, em/mw ENABLE, pc_en=1.
- **Halt:** halt_mem=1 together with branch_taken_ex=1.
  - That cycle: mw ENABLE, em NOP, fd/de STALL, pc_en=0.
  - Next cycle: halted=1, all stages STALL.
  - stall_count then stays frozen for 10 further cycles.
  - nRST then returns the FSM to RUN.
- **Counter saturation:** CNT_W=4, ihit=0 held for 20 cycles → stall_count stops at 15.
